// File: rtl/key_debounce.sv
// Input conditioner: optional inversion, 2-flop synchroniser and a per-bit persistence counter.
// Build macro KEY_DEBOUNCE_EDGE_EN adds registered single-cycle rise_pulse/fall_pulse outputs.
module key_debounce #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter bit INVERT          = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] stable_out
`ifdef KEY_DEBOUNCE_EDGE_EN
  ,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse
`endif
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] raw_pol;
  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] differ;
  logic [WIDTH-1:0] accept;
  logic [CW-1:0]    cnt [WIDTH];

  assign raw_pol = INVERT ? ~raw_in : raw_in;

  // Synchroniser stage: reset values are post-inversion, so an idle key reads 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= raw_pol;
      s2 <= s1;
    end
  end

  always_comb begin
    differ = '0;
    accept = '0;
    for (int i = 0; i < WIDTH; i++) begin
      differ[i] = s2[i] ^ stable_out[i];
      accept[i] = differ[i] && (cnt[i] == CNT_LAST);
    end
  end

  // Debounce stage: any cycle of agreement restarts the count; the counter stops at CNT_LAST.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
      stable_out <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (!differ[i] || accept[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
      stable_out <= stable_out ^ accept;
    end
  end

`ifdef KEY_DEBOUNCE_EDGE_EN
  // Edge stage: pulses are set on the same edge that flips stable_out.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rise_pulse <= '0;
      fall_pulse <= '0;
    end else begin
      rise_pulse <= accept & s2;
      fall_pulse <= accept & ~s2;
    end
  end
`endif

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: directed test-plan scenarios plus random stimulus, checked
// against a sliding-window model (a level is accepted once its last D samples agree).
module tb_key_debounce;

  localparam int W = 4;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [W-1:0] raw;
  logic [W-1:0] raw_i;
  logic [W-1:0] st;
  logic [W-1:0] st_i;
`ifdef KEY_DEBOUNCE_EDGE_EN
  logic [W-1:0] rise, fall, rise_i, fall_i;
`endif

  always #5 clk = ~clk;

  key_debounce #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .INVERT(1'b0)) dut (
    .clk(clk), .reset_n(reset_n), .raw_in(raw), .stable_out(st)
`ifdef KEY_DEBOUNCE_EDGE_EN
    , .rise_pulse(rise), .fall_pulse(fall)
`endif
  );

  key_debounce #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .INVERT(1'b1)) dut_inv (
    .clk(clk), .reset_n(reset_n), .raw_in(raw_i), .stable_out(st_i)
`ifdef KEY_DEBOUNCE_EDGE_EN
    , .rise_pulse(rise_i), .fall_pulse(fall_i)
`endif
  );

  int tests = 0;
  int fails = 0;

  // hist[u][j] holds the (post-inversion) level sampled j edges ago.
  logic [W-1:0] hist [2][D+2];
  logic [W-1:0] m_st [2];
`ifdef KEY_DEBOUNCE_EDGE_EN
  logic [W-1:0] m_rise [2];
  logic [W-1:0] m_fall [2];
`endif

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input int u, input logic [W-1:0] smp);
    bit held;
    if (!reset_n) begin
      for (int j = 0; j < D + 2; j++) hist[u][j] = '0;
      m_st[u] = '0;
`ifdef KEY_DEBOUNCE_EDGE_EN
      m_rise[u] = '0;
      m_fall[u] = '0;
`endif
    end else begin
      for (int j = D + 1; j > 0; j--) hist[u][j] = hist[u][j-1];
      hist[u][0] = smp;
`ifdef KEY_DEBOUNCE_EDGE_EN
      m_rise[u] = '0;
      m_fall[u] = '0;
`endif
      // Samples 2..D+1 edges old are the ones the counter has seen through s2.
      for (int b = 0; b < W; b++) begin
        held = 1'b1;
        for (int j = 2; j <= D + 1; j++)
          if (hist[u][j][b] == m_st[u][b]) held = 1'b0;
        if (held) begin
          m_st[u][b] = ~m_st[u][b];
`ifdef KEY_DEBOUNCE_EDGE_EN
          if (m_st[u][b]) m_rise[u][b] = 1'b1;
          else            m_fall[u][b] = 1'b1;
`endif
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge(0, raw);
    model_edge(1, ~raw_i);
    #1;
    chk("model_stable", st, m_st[0]);
    chk("model_stable_inv", st_i, m_st[1]);
`ifdef KEY_DEBOUNCE_EDGE_EN
    chk("model_rise", rise, m_rise[0]);
    chk("model_fall", fall, m_fall[0]);
    chk("model_rise_inv", rise_i, m_rise[1]);
    chk("model_fall_inv", fall_i, m_fall[1]);
    chk("pulse_exclusive", rise & fall, 4'b0000);
`endif
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    for (int u = 0; u < 2; u++) begin
      for (int j = 0; j < D + 2; j++) hist[u][j] = '0;
      m_st[u] = '0;
    end
    reset_n = 1'b0;
    raw     = '0;
    raw_i   = '1;
    ticks(3);
    chk("reset_stable", st, 4'b0000);
    chk("reset_stable_inv", st_i, 4'b0000);
    reset_n = 1'b1;
    ticks(3);

    // Clean press: sampled at edge k, visible at k+5.
    raw = 4'b0001;
    tick();
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("press_early", st, 4'b0000);
    end
    tick();
    chk("press_k5", st, 4'b0001);
`ifdef KEY_DEBOUNCE_EDGE_EN
    chk("press_rise", rise, 4'b0001);
    tick();
    chk("press_rise_once", rise, 4'b0000);
`else
    tick();
`endif

    // Release.
    raw = 4'b0000;
    tick();
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("release_early", st, 4'b0001);
    end
    tick();
    chk("release_k5", st, 4'b0000);
`ifdef KEY_DEBOUNCE_EDGE_EN
    chk("release_fall", fall, 4'b0001);
`endif
    ticks(3);

    // Bounce: 3 high, 1 low, 3 high, then low.
    raw = 4'b0100; ticks(3);
    raw = 4'b0000; ticks(1);
    raw = 4'b0100; ticks(3);
    raw = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("bounce_reject", st, 4'b0000);
    end

    // Independent bits: bit 0 at k, bit 3 at k+2.
    raw = 4'b0001;
    tick();
    tick();
    raw = 4'b1001;
    tick();
    tick(); chk("indep_k3", st, 4'b0000);
    tick(); chk("indep_k4", st, 4'b0000);
    tick(); chk("indep_k5", st, 4'b0001);
    tick(); chk("indep_k6", st, 4'b0001);
    tick(); chk("indep_k7", st, 4'b1001);
    raw = 4'b0000;
    ticks(8);

    // Reset mid-count.
    raw = 4'b0010;
    tick();
    tick();
    reset_n = 1'b0;
    #1 chk("reset_async", st, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset_hold", st, 4'b0000);
    end
    reset_n = 1'b1;
    tick();
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("reset_restart_early", st, 4'b0000);
    end
    tick();
    chk("reset_restart_r5", st, 4'b0010);
    raw = 4'b0000;
    ticks(8);

    // INVERT=1: active-low key 0 pressed.
    chk("inv_idle", st_i, 4'b0000);
    raw_i = 4'b1110;
    tick();
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("inv_early", st_i, 4'b0000);
    end
    tick();
    chk("inv_k5", st_i, 4'b0001);
    raw_i = 4'b1111;
    ticks(8);

    // Random phase: sparse bit flips so both accepted levels and glitches occur.
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(3) == 0) raw[$urandom_range(W-1)]   = ~raw[$urandom_range(W-1)];
      if ($urandom_range(3) == 0) raw_i[$urandom_range(W-1)] = ~raw_i[$urandom_range(W-1)];
      if ($urandom_range(3) == 0) raw = raw ^ W'($urandom_range(15));
      if ($urandom_range(149) == 0) reset_n = 1'b0;
      else reset_n = 1'b1;
      tick();
    end
    reset_n = 1'b1;
    ticks(D + 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
